// File: rtl/inv_rotate_permute_func.sv
// Inverse rho/pi step: loads 64 state lines, then writes back
// out[x][y][z] = in[y][(2x+3y) mod 5][(z + r[x][y]) mod 64].
module inv_rotate_permute_func #(
    parameter int unsigned LINES = 64,
    parameter int unsigned WIDTH = 25
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WIDTH-1:0]           line_in,
    output logic [$clog2(LINES)-1:0]   cnt_value,
    output logic                       write_enable,
    output logic [$clog2(LINES)-1:0]   wr_addr,
    output logic [WIDTH-1:0]           write_value,
    output logic                       donee
);

    localparam int unsigned ADDR_W = $clog2(LINES);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(LINES - 1);

    // Keccak rho offsets indexed by bit 5*y + x
    localparam logic [ADDR_W-1:0] ROT [WIDTH] = '{
        ADDR_W'(0),  ADDR_W'(1),  ADDR_W'(62), ADDR_W'(28), ADDR_W'(27),
        ADDR_W'(36), ADDR_W'(44), ADDR_W'(6),  ADDR_W'(55), ADDR_W'(20),
        ADDR_W'(3),  ADDR_W'(10), ADDR_W'(43), ADDR_W'(25), ADDR_W'(39),
        ADDR_W'(41), ADDR_W'(45), ADDR_W'(15), ADDR_W'(21), ADDR_W'(8),
        ADDR_W'(18), ADDR_W'(2),  ADDR_W'(61), ADDR_W'(56), ADDR_W'(14)
    };

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0]   line_buf_q [LINES];
    logic [WIDTH-1:0]   line_buf_d [LINES];
    logic [WIDTH-1:0]   emit_value;

    // Each output bit is a fixed source bit column of a rotated source line
    for (genvar g = 0; g < int'(WIDTH); g++) begin : g_bit
        localparam int unsigned GX  = g % 5;
        localparam int unsigned GY  = g / 5;
        localparam int unsigned SRC = 5 * ((2 * GX + 3 * GY) % 5) + GY;
        logic [ADDR_W-1:0] src_line;
        assign src_line      = cnt_q + ROT[g];
        assign emit_value[g] = line_buf_q[src_line][SRC];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            line_buf_q <= '{default: '0};
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            line_buf_q <= line_buf_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        line_buf_d   = line_buf_q;
        cnt_value    = '0;
        write_enable = 1'b0;
        wr_addr      = '0;
        write_value  = '0;
        donee        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD;
                    cnt_d   = '0;
                end
            end
            LOAD: begin
                cnt_value         = cnt_q;
                line_buf_d[cnt_q] = line_in;
                cnt_d             = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) state_d = EMIT;
            end
            EMIT: begin
                write_enable = 1'b1;
                wr_addr      = cnt_q;
                write_value  = emit_value;
                cnt_d        = cnt_q + ADDR_W'(1);
                if (cnt_q == LAST) state_d = DONE;
            end
            DONE: begin
                donee   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_inv_rotate_permute_func.sv
// Scoreboard bench for inv_rotate_permute_func: stimulus pushes expected
// writes into a queue, a negedge monitor pops and compares them.
module tb_inv_rotate_permute_func;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [24:0] line_in;
    logic [5:0]  cnt_value;
    logic        write_enable;
    logic [5:0]  wr_addr;
    logic [24:0] write_value;
    logic        donee;

    inv_rotate_permute_func #(.LINES(64), .WIDTH(25)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .line_in     (line_in),
        .cnt_value   (cnt_value),
        .write_enable(write_enable),
        .wr_addr     (wr_addr),
        .write_value (write_value),
        .donee       (donee)
    );

    always #5 clk = ~clk;

    logic [24:0] mem  [64];
    logic [24:0] expl [64];
    assign line_in = mem[cnt_value];

    typedef struct packed {
        logic [5:0]  addr;
        logic [24:0] val;
    } exp_t;
    exp_t expq[$];
    exp_t e;

    localparam int R [25] = '{
        0, 1, 62, 28, 27,
        36, 44, 6, 55, 20,
        3, 10, 43, 25, 39,
        41, 45, 15, 21, 8,
        18, 2, 61, 56, 14
    };

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int start_cyc = 0;
    int started = 0;
    int done_count = 0;
    int writes = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: compare every presented write and completion pulse
    always @(negedge clk) begin
        if (!rst) writes = 0;
        if (write_enable) begin
            if (expq.size() == 0) begin
                chk("unexpected_write", 32'd1, 32'd0);
            end else begin
                e = expq.pop_front();
                chk("wr_addr", 32'(wr_addr), 32'(e.addr));
                chk("write_value", 32'(write_value), 32'(e.val));
                writes++;
            end
        end
        if (donee) begin
            chk("donee_expected", 32'(started), 32'(done_count + 1));
            chk("donee_cycle", 32'(cyc - start_cyc), 32'd129);
            chk("write_count", 32'(writes), 32'd64);
            chk("queue_empty", 32'(expq.size()), 32'd0);
            writes = 0;
            done_count++;
        end
    end

    task automatic push_all();
        for (int i = 0; i < 64; i++) expq.push_back(exp_t'{addr: 6'(i), val: expl[i]});
    endtask

    task automatic fill(input logic [24:0] in_v, input logic [24:0] out_v);
        for (int i = 0; i < 64; i++) begin
            mem[i]  = in_v;
            expl[i] = out_v;
        end
    endtask

    // Run one operation; optionally pulse start in cycles 10 and 100
    task automatic run_op(input bit busy);
        int k;
        int dc;
        push_all();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        started++;
        dc = done_count;
        @(negedge clk);
        start = 1'b0;
        k = 1;
        while (done_count == dc && k < 300) begin
            if (k <= 64) chk("cnt_value_load", 32'(cnt_value), 32'(k - 1));
            else if (k <= 128) chk("cnt_value_emit", 32'(cnt_value), 32'd0);
            start = (busy && (k == 10 || k == 100)) ? 1'b1 : 1'b0;
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        if (done_count == dc) chk("donee_timeout", 32'd0, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Golden forward rho then pi applied to S gives the input image
    task automatic forward_round_trip();
        logic [24:0] s [64];
        int a, b, zz;
        for (int z = 0; z < 64; z++) begin
            s[z]   = 25'($urandom);
            mem[z] = '0;
        end
        for (int z = 0; z < 64; z++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 5; x++) begin
                    a  = y;
                    b  = (2 * x + 3 * y) % 5;
                    zz = (z + R[5 * y + x]) % 64;
                    mem[zz][5 * b + a] = s[z][5 * y + x];
                end
        for (int z = 0; z < 64; z++) expl[z] = s[z];
        run_op(1'b0);
    endtask

    initial begin
        int dc;
        rst   = 1'b0;
        start = 1'b0;
        fill(25'h0, 25'h0);
        #12;
        chk("reset_write_enable", 32'(write_enable), 32'd0);
        chk("reset_wr_addr", 32'(wr_addr), 32'd0);
        chk("reset_write_value", 32'(write_value), 32'd0);
        chk("reset_donee", 32'(donee), 32'd0);
        chk("reset_cnt_value", 32'(cnt_value), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // lane (0,0) stays in place with zero rotation
        fill(25'h0000001, 25'h0000001);
        run_op(1'b0);

        // single bit x=1,y=0,z=0 lands on line 20, bit 6
        fill(25'h0, 25'h0);
        mem[0]   = 25'h0000002;
        expl[20] = 25'h0000040;
        run_op(1'b0);

        fill(25'h1FFFFFF, 25'h1FFFFFF);
        run_op(1'b0);

        fill(25'h0, 25'h0);
        run_op(1'b0);

        // start pulses during LOAD and EMIT must be ignored
        fill(25'h0000001, 25'h0000001);
        run_op(1'b1);
        chk("busy_single_donee", 32'(done_count), 32'(started));

        // reset in the middle of EMIT
        fill(25'h0000001, 25'h0000001);
        push_all();
        @(negedge clk);
        start = 1'b1;
        start_cyc = cyc;
        started++;
        @(negedge clk);
        start = 1'b0;
        repeat (79) @(negedge clk);
        @(posedge clk);
        #2 rst = 1'b0;
        #1;
        chk("midreset_write_enable", 32'(write_enable), 32'd0);
        chk("midreset_wr_addr", 32'(wr_addr), 32'd0);
        chk("midreset_write_value", 32'(write_value), 32'd0);
        chk("midreset_donee", 32'(donee), 32'd0);
        chk("midreset_cnt_value", 32'(cnt_value), 32'd0);
        expq.delete();
        started = done_count;
        dc = done_count;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (150) @(negedge clk);
        chk("no_donee_after_reset", 32'(done_count), 32'(dc));

        fill(25'h0000001, 25'h0000001);
        run_op(1'b0);

        for (int seed = 0; seed < 20; seed++) forward_round_trip();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/inv_rotate_permute_func.md
Name: inv_rotate_permute_func

Overview:
- Decoder-side inverse of the encoder's rotate (rho) and permutation (pi) steps.
- Operates on a 64-line x 25-bit state. Line z is slice z; bit i = 5*y + x, with x,y in 0..4.
- Reads the whole state through the same line_in/cnt_value interface that the step modules use.
- Applies pi^-1 then rho^-1, and writes the 64 result lines back with write_enable/wr_addr/write_value.
- Sits in the decode datapath between inverse revaluate (chi^-1) and inverse colParity (theta^-1).

Parameters:
- LINES, 64, number of slices (lane length). Must be 64 for Keccak-style offsets.
- WIDTH, 25, bits per line (5x5 plane).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins an operation when in IDLE.
- line_in  in  25  source line addressed by cnt_value; combinational read, same cycle.
- cnt_value  out  6  read address during LOAD; otherwise 0.
- write_enable  out  1  high during EMIT.
- wr_addr  out  6  destination line index during EMIT.
- write_value  out  25  result line for wr_addr.
- donee  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=0, async): state=IDLE, cnt=0, internal buffer buf[0..63]=0. All outputs 0.
- States: IDLE, LOAD, EMIT, DONE. The 6-bit counter cnt is shared by LOAD and EMIT.
- IDLE:
  - start=1 -> LOAD with cnt=0.
  - start is ignored in every other state (no restart, no queuing).
- LOAD:
  - cnt_value=cnt; buf[cnt] <= line_in at the clock edge; cnt increments.
  - When cnt=63 -> EMIT with cnt=0 (6-bit wrap).
- EMIT:
  - write_enable=1, wr_addr=cnt, write_value=f(buf,cnt), all combinational from state/cnt/buf; cnt increments.
  - When cnt=63 -> DONE.
- DONE: donee=1 for exactly one cycle -> IDLE.
- Transform, with out bit (x,y) of slice z and x,y,z ranges as above:
  - out[x][y][z] = buf[(2x+3y) mod 5 -> bit column y... ] is written in full as out[x][y][z] = in[y][(2x+3y) mod 5][(z + r[x][y]) mod 64].
  - Bit (a,b) of line s is buf[s][5*b+a].
- Rho offsets r[x][y] (Keccak table), listed by y:
  - y=0: 0, 1, 62, 28, 27
  - y=1: 36, 44, 6, 55, 20
  - y=2: 3, 10, 43, 25, 39
  - y=3: 41, 45, 15, 21, 8
  - y=4: 18, 2, 61, 56, 14
- Index arithmetic: z + r is computed in 6 bits with natural wrap. No other arithmetic is present; all 25 bit-select muxes are constants per bit.
- Timing, start sampled at edge 0:
  - LOAD occupies cycles 1..64.
  - EMIT occupies cycles 65..128, with exactly 64 write_enable cycles and wr_addr 0..63 in order.
  - donee is high in cycle 129.
  - Earliest next accepted start is in cycle 130.
- Source/destination aliasing is allowed: all reads complete before any write.
- Reset mid-operation: returns to IDLE immediately. No write_enable or donee is generated afterwards. buf is cleared.
- buf contents persist after DONE until the next LOAD overwrites them. They are not observable on outputs.

Test Plan:
- Reset: assert rst=0 mid-EMIT -> write_enable, wr_addr, write_value, donee, cnt_value all 0 the same cycle. After release, idles until start.
- Lane (0,0) pass-through: all lines = 25'h0000001 -> every written line = 25'h0000001, wr_addr 0..63 in order. donee exactly in cycle 129 after start.
- Single bit: line 0 = 25'h0000002 (x=1,y=0,z=0), others 0 -> line 20 = 25'h0000040; all other 63 lines = 0.
- Uniform data: all-ones input -> all 64 outputs 25'h1FFFFFF. All-zero input -> all outputs 0.
- Round trip: random 64x25 state S, apply the golden forward rho then pi, feed the result -> written lines equal S exactly. Run 20 seeds.
- Busy start: pulse start in cycle 10 (LOAD) and cycle 100 (EMIT) -> ignored. Exactly one donee, 64 writes, cnt_value sequence 0..63 unbroken.
